// File: rtl/decoder_pkg.sv
// Shared definitions for the scanning line decoder: mode codes, FSM encoding, pattern helper.
// Latency: n/a (package).
// Backpressure: n/a (package).
package decoder_pkg;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    // Widest address the decode helper supports; instances slice the low 2**AW bits.
    localparam int MAX_AW = 8;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DIRECT = 2'd1;
    localparam logic [1:0] ST_SCAN   = 2'd2;

    typedef enum logic [1:0] {
        IDLE   = ST_IDLE,
        DIRECT = ST_DIRECT,
        SCAN   = ST_SCAN
    } state_t;

    // One-hot (s=1) or one-cold (s=0) pattern with index idx selected.
    function automatic logic [2**MAX_AW-1:0] decode_pol(input logic [MAX_AW-1:0] idx,
                                                        input logic              s);
        logic [2**MAX_AW-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return s ? v : ~v;
    endfunction

endpackage

// File: rtl/scan_prescaler.sv
// Scan step prescaler: counts 0..div and emits a tick on the terminal count.
// Latency: tick is combinational from the current count; count updates each enabled edge.
// Backpressure: none; en freezes the count, clr zeroes it.
module scan_prescaler #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);

    logic [DIV_W-1:0] cnt;

    // >= rather than == so a lowered div forces an immediate tick instead of a long run-around.
    assign tick = en && !clr && (cnt >= div);

    // Count register: reset/clear to zero, advance only while enabled, restart after a tick.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en) begin
            if (cnt >= div) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + DIV_W'(1);
            end
        end
    end

endmodule

// File: rtl/decoder_scan_n.sv
// Registered N-to-2^N decoder with enable, polarity select and autonomous prescaled scan.
// Latency: one clk from E/S/M/A/LAST/TICK_DIV to Y/IDX/WRAP.
// Backpressure: none; E=0 blanks the outputs and freezes the scan position.
module decoder_scan_n
    import decoder_pkg::*;
#(
    parameter int AW    = 3,
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             E,
    input  logic             S,
    input  logic             M,
    input  logic [AW-1:0]    A,
    input  logic [AW-1:0]    LAST,
    input  logic [DIV_W-1:0] TICK_DIV,
    output logic [2**AW-1:0] Y,
    output logic [AW-1:0]    IDX,
    output logic             WRAP
);

    localparam int OW = 2**AW;

    state_t        state;
    state_t        state_nxt;
    logic [OW-1:0] y_nxt;
    logic [AW-1:0] idx_nxt;
    logic          wrap_nxt;
    logic          psc_en;
    logic          psc_clr;
    logic          tick;

    // Only a cycle already in SCAN that stays in SCAN advances the prescaler; the
    // IDLE->SCAN edge just re-shows the held index so the dwell is never shortened.
    assign psc_en  = (state == SCAN) && E && (M == MODE_SCAN);
    // DIRECT holds the prescaler at zero, which also gives a fresh count on DIRECT->SCAN.
    assign psc_clr = E && ((M == MODE_DIRECT) || (state == DIRECT));

    scan_prescaler #(
        .DIV_W (DIV_W)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .en   (psc_en),
        .clr  (psc_clr),
        .div  (TICK_DIV),
        .tick (tick)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state plus the next Y/IDX/WRAP values for the output registers.
    always_comb begin
        state_nxt = state;
        idx_nxt   = IDX;
        wrap_nxt  = 1'b0;
        y_nxt     = S ? '0 : '1;

        if (!E) begin
            state_nxt = IDLE;
        end else if (M == MODE_SCAN) begin
            state_nxt = SCAN;
        end else begin
            state_nxt = DIRECT;
        end

        case (state_nxt)
            DIRECT: begin
                idx_nxt = A;
                y_nxt   = OW'(decode_pol(MAX_AW'(A), S));
            end
            SCAN: begin
                if (state == DIRECT) begin
                    idx_nxt = '0;
                end else if (tick) begin
                    // >= so a LAST lowered below the current index wraps at once.
                    if (IDX >= LAST) begin
                        idx_nxt  = '0;
                        wrap_nxt = 1'b1;
                    end else begin
                        idx_nxt = IDX + AW'(1);
                    end
                end
                y_nxt = OW'(decode_pol(MAX_AW'(idx_nxt), S));
            end
            default: begin
                idx_nxt = IDX;
            end
        endcase
    end

    // Output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            Y    <= '0;
            IDX  <= '0;
            WRAP <= 1'b0;
        end else begin
            Y    <= y_nxt;
            IDX  <= idx_nxt;
            WRAP <= wrap_nxt;
        end
    end

endmodule

// File: tb/tb_decoder_scan_n.sv
// Directed bench for decoder_scan_n: an AW=3 instance and an AW=2 instance.
// Latency: checks sample 1ns after each rising edge.
// Backpressure: n/a.
module tb_decoder_scan_n;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // AW=3 instance
    logic        rst, e, s, m;
    logic [2:0]  a, last;
    logic [15:0] div;
    logic [7:0]  y;
    logic [2:0]  idx;
    logic        wrap;

    // AW=2 instance
    logic        rst2, e2, s2, m2;
    logic [1:0]  a2, last2;
    logic [15:0] div2;
    logic [3:0]  y2;
    logic [1:0]  idx2;
    logic        wrap2;

    int n_cmp = 0;
    int n_err = 0;

    decoder_scan_n #(.AW(3), .DIV_W(16)) u_dut (
        .clk(clk), .rst(rst), .E(e), .S(s), .M(m), .A(a), .LAST(last),
        .TICK_DIV(div), .Y(y), .IDX(idx), .WRAP(wrap)
    );

    decoder_scan_n #(.AW(2), .DIV_W(16)) u_dut2 (
        .clk(clk), .rst(rst2), .E(e2), .S(s2), .M(m2), .A(a2), .LAST(last2),
        .TICK_DIV(div2), .Y(y2), .IDX(idx2), .WRAP(wrap2)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check3(input string tag, input logic [7:0] ey, input logic [2:0] ei,
                          input logic ew);
        check_val({tag, ".Y"}, 32'(y), 32'(ey));
        check_val({tag, ".IDX"}, 32'(idx), 32'(ei));
        check_val({tag, ".WRAP"}, 32'(wrap), 32'(ew));
    endtask

    int          scan_idx[13] = '{0, 0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3, 0};
    int          resume_idx[3] = '{2, 2, 3};
    int          last_idx[3] = '{4, 5, 6};
    int          low_idx[4] = '{0, 1, 2, 0};
    int          low_wrap[4] = '{1, 0, 0, 1};
    int          rst_idx[4] = '{0, 0, 0, 1};
    int          aw2_idx[8] = '{0, 1, 2, 3, 0, 1, 2, 3};
    logic [7:0]  one8;
    logic [3:0]  one4;

    initial begin
        one8 = 8'h01;
        one4 = 4'h1;
        rst = 1'b1; e = 1'b0; s = 1'b1; m = 1'b0; a = '0; last = '0; div = '0;
        rst2 = 1'b1; e2 = 1'b0; s2 = 1'b0; m2 = 1'b0; a2 = '0; last2 = '0; div2 = '0;

        step();
        step();
        check3("reset", 8'h00, 3'd0, 1'b0);
        check_val("reset2.Y", 32'(y2), 32'h0);

        // DIRECT decode, then polarity flip
        rst = 1'b0; e = 1'b1; s = 1'b1; m = 1'b0; a = 3'd5;
        step();
        check3("direct5", 8'b0010_0000, 3'd5, 1'b0);
        s = 1'b0;
        step();
        check3("direct5_lo", 8'b1101_1111, 3'd5, 1'b0);

        // DIRECT -> SCAN, LAST=3, TICK_DIV=2
        s = 1'b1; m = 1'b1; last = 3'd3; div = 16'd2;
        for (int i = 0; i < 13; i++) begin
            step();
            check3($sformatf("scan%0d", i), one8 << scan_idx[i], 3'(scan_idx[i]), (i == 12));
        end

        // advance to IDX=2 with one prescaler count used
        for (int i = 0; i < 7; i++) step();
        check3("at2", 8'h04, 3'd2, 1'b0);

        // freeze for 5 cycles
        e = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check3($sformatf("frz%0d", i), 8'h00, 3'd2, 1'b0);
        end

        // resume with the remaining count
        e = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check3($sformatf("res%0d", i), one8 << resume_idx[i], 3'(resume_idx[i]), 1'b0);
        end

        // fast scan up to 6, then drop LAST below the index
        last = 3'd7; div = 16'd0;
        for (int i = 0; i < 3; i++) begin
            step();
            check3($sformatf("fast%0d", i), one8 << last_idx[i], 3'(last_idx[i]), 1'b0);
        end
        last = 3'd2;
        for (int i = 0; i < 4; i++) begin
            step();
            check3($sformatf("low%0d", i), one8 << low_idx[i], 3'(low_idx[i]), low_wrap[i][0]);
        end

        // reset in the middle of a scan with E=1, M=1
        last = 3'd3; div = 16'd2;
        step();
        step();
        rst = 1'b1;
        step();
        check3("midrst", 8'h00, 3'd0, 1'b0);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            check3($sformatf("post%0d", i), one8 << rst_idx[i], 3'(rst_idx[i]), 1'b0);
        end

        // polarity flip mid-scan leaves the index alone
        s = 1'b0;
        step();
        check3("scan_lo", 8'hFD, 3'd1, 1'b0);

        // disabled with S=0 gives all ones
        e = 1'b0;
        step();
        check3("off_lo", 8'hFF, 3'd1, 1'b0);

        // back to DIRECT
        e = 1'b1; s = 1'b1; m = 1'b0; a = 3'd3;
        step();
        check3("direct3", 8'h08, 3'd3, 1'b0);

        // AW=2, active-low scan every cycle
        rst2 = 1'b0; e2 = 1'b1; s2 = 1'b0; m2 = 1'b1; last2 = 2'd3; div2 = 16'd0;
        for (int i = 0; i < 8; i++) begin
            step();
            check_val($sformatf("aw2_%0d.Y", i), 32'(y2), 32'(4'(~(one4 << aw2_idx[i]))));
            check_val($sformatf("aw2_%0d.IDX", i), 32'(idx2), 32'(aw2_idx[i]));
            check_val($sformatf("aw2_%0d.WRAP", i), 32'(wrap2), 32'(i == 4));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/decoder_scan_n.md
Name: decoder_scan_n

Overview:
- Parametrised, registered N-to-2^N line decoder with enable (E) and output-polarity select (S).
- Adds an autonomous scan mode: an internal prescaled index walks outputs 0..LAST. Used for multiplexed display digit strobes and row/column selects.
- Sits between control logic (or a free-running scan) and the display/keypad drivers.

Parameters:
AW, 3, address width; output width is 2**AW.
DIV_W, 16, width of the scan prescaler divide value.

Ports:
clk  in  1  system clock.
rst  in  1  synchronous, active-high reset.
E  in  1  enable; 0 forces all outputs to the inactive level.
S  in  1  polarity; 1 = active-high one-hot, 0 = active-low one-cold.
M  in  1  mode; 0 = DIRECT (decode A), 1 = SCAN (decode internal index).
A  in  AW  address in DIRECT mode.
LAST  in  AW  last index visited in SCAN mode; wrap point.
TICK_DIV  in  DIV_W  scan step period minus 1, in clk cycles.
Y  out  2**AW  decoded output, registered.
IDX  out  AW  index currently driven on Y, registered.
WRAP  out  1  one-cycle pulse when the scan index wraps LAST->0.

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst). rst has priority over all other inputs in the same cycle.
- Reset values: Y=0, IDX=0, WRAP=0, prescaler=0, state=IDLE.
- Inactive pattern: all zeros when S=1, all ones when S=0.
- Active pattern for index k: bit k=1 and the rest 0 when S=1; bit k=0 and the rest 1 when S=0.
- Latency: Y/IDX reflect the E, S, M, A sampled at the previous clk edge, i.e. one cycle.
- FSM states (evaluated each cycle):
  - IDLE: E=0. Y=inactive, IDX holds, prescaler holds (scan frozen), WRAP=0. Exit to DIRECT if E=1 and M=0, to SCAN if E=1 and M=1.
  - DIRECT: Y=active(A), IDX=A, prescaler=0, WRAP=0.
  - SCAN: Y=active(IDX). Prescaler counts 0..TICK_DIV. When prescaler==TICK_DIV it produces a tick and clears to 0.
    - On a tick: if IDX>=LAST, then IDX=0 and WRAP=1 for that cycle; else IDX=IDX+1.
- TICK_DIV=0: tick every cycle.
- LAST=0: IDX stays 0 and WRAP pulses on every tick.
- LAST lowered below the current IDX: the next tick wraps to 0 with WRAP=1; there is no out-of-range output.
- Entering SCAN from DIRECT (M 0->1 with E=1): IDX=0 and prescaler=0 on entry. The first Y is active(0), and the first step comes TICK_DIV+1 cycles later.
- Entering SCAN from IDLE (E 0->1, M=1): resume from the held IDX and prescaler (freeze/resume).
- SCAN->DIRECT: takes effect on the next edge; prescaler clears.
- S toggling mid-scan: Y inverts on the next edge; IDX and prescaler are unaffected.
- All arithmetic is unsigned modulo the field width. The prescaler never exceeds TICK_DIV; if TICK_DIV is lowered below the prescaler count, the next cycle is a tick.

Decomposition:
- Shared package decoder_pkg:
  - MODE_DIRECT=1'b0, MODE_SCAN=1'b1.
  - State encoding localparams: IDLE, DIRECT, SCAN.
  - Function decode_pol(idx, s) returning the 2**AW-bit pattern.
- One sub-module, scan_prescaler (DIV_W): inputs clk, rst, en, clr, div; output tick.
- Top level holds the FSM, the IDX register and the output register.

Test Plan:
- AW=3. rst=1 for 2 cycles, then E=1, S=1, M=0, A=5 -> cycle after: Y=8'b0010_0000, IDX=5, WRAP=0. Then S=0 -> Y=8'b1101_1111.
- E=1, S=1, M=1, LAST=3, TICK_DIV=2 from DIRECT -> IDX sequence 0,0,0,1,1,1,2,2,2,3,3,3,0. WRAP=1 only in the cycle IDX returns to 0. Y=8'h01,02,04,08.
- Mid-scan at IDX=2, E=0 for 5 cycles -> Y=8'h00 and IDX holds 2. E=1 again -> Y=8'h04 and scan resumes with the remaining prescaler count.
- SCAN at IDX=6 with LAST=7, change LAST=2, TICK_DIV=0 -> next cycle IDX=0 with WRAP=1, then 1,2,0...
- rst=1 asserted mid-scan together with E=1, M=1 -> next cycle Y=0, IDX=0, WRAP=0. After release, Y=8'h01 with a full TICK_DIV+1 dwell.
- AW=2, S=0, M=1, LAST=3, TICK_DIV=0 -> Y cycles 4'b1110,1101,1011,0111, with WRAP every 4 cycles.
